// File: rtl/sram_controller.sv
// sram_controller: MEM-stage bridge from 32-bit word requests to a 16-bit
// asynchronous SRAM. Each word is moved as two halfword accesses, low half
// first, with `ready` held low (pipeline freeze) until the word completes.
module sram_controller #(
  parameter int MEM_BASE      = 1024,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OF_N
);

  typedef enum logic [2:0] {
    S_IDLE, S_W_LO, S_W_HI, S_R_LO, S_R_HI, S_DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_read_data;

  logic        w_last;
  logic [18:0] w_eff;
  logic        w_access;
  logic        w_hi;
  logic        w_wr;
  logic [15:0] w_dq_out;
  logic        w_unused;

  assign w_last = (r_cnt == LAST);

  // Only bits [18:2] of the rebased address reach the bus, so the
  // subtraction is done on 19 bits; modulo arithmetic keeps them exact.
  assign w_eff    = address[18:0] - 19'(MEM_BASE);
  assign w_unused = ^{address[31:19], address[1:0]};

  // Sequencer: request capture, per-half timing and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_read_data <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= 4'd0;
          if (wr_en)      r_state <= S_W_LO;
          else if (rd_en) r_state <= S_R_LO;
        end
        S_W_LO: begin
          if (w_last) begin
            r_cnt   <= 4'd0;
            r_state <= S_W_HI;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_W_HI: begin
          if (w_last) begin
            r_cnt   <= 4'd0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_R_LO: begin
          if (w_last) begin
            r_cnt             <= 4'd0;
            r_state           <= S_R_HI;
            r_read_data[15:0] <= SRAM_DQ;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_R_HI: begin
          if (w_last) begin
            r_cnt              <= 4'd0;
            r_state            <= S_DONE;
            r_read_data[31:16] <= SRAM_DQ;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DONE: begin
          r_cnt   <= 4'd0;
          r_state <= S_IDLE;
        end
        default: begin
          r_cnt   <= 4'd0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Bus decode straight from state; address and write data pass through live.
  always_comb begin
    w_access  = 1'b0;
    w_hi      = 1'b0;
    w_wr      = 1'b0;
    case (r_state)
      S_W_LO: begin w_access = 1'b1; w_wr = 1'b1;              end
      S_W_HI: begin w_access = 1'b1; w_wr = 1'b1; w_hi = 1'b1; end
      S_R_LO: begin w_access = 1'b1;                           end
      S_R_HI: begin w_access = 1'b1; w_hi = 1'b1;              end
      default: ;
    endcase

    SRAM_CE_N = ~w_access;
    SRAM_UB_N = ~w_access;
    SRAM_LB_N = ~w_access;
    SRAM_WE_N = ~(w_access & w_wr);
    SRAM_OF_N = ~(w_access & ~w_wr);
    SRAM_ADDR = w_access ? {w_eff[18:2], w_hi} : 18'd0;
    w_dq_out  = w_hi ? write_data[31:16] : write_data[15:0];
  end

  // Ready means "nothing pending": the first IDLE cycle of a request
  // already freezes the pipeline.
  always_comb begin
    ready = 1'b0;
    if (r_state == S_DONE)                       ready = 1'b1;
    else if (r_state == S_IDLE && !wr_en && !rd_en) ready = 1'b1;
  end

  assign SRAM_DQ   = (w_access & w_wr) ? w_dq_out : 16'bz;
  assign read_data = r_read_data;

endmodule
